// File: rtl/dmem_responder_if.sv
// Request/response bundle between a datapath (master) and dmem_responder (slave).
interface dmem_responder_if #(
    parameter int unsigned NBITS = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [NBITS-1:0] req_addr;
    logic [NBITS-1:0] req_wdata;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic             rsp_valid;
    logic [NBITS-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: one outstanding byte/half/word access,
// little-endian storage, single-cycle response pulse with error flag.
module dmem_responder #(
    parameter int unsigned NBITS   = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             we_q, uns_q, err_q;
    logic [1:0]       size_q;
    logic [NBITS-1:0] addr_q, wdata_q, rdata_q;
    logic [NBITS-1:0] mem_q [DEPTH];

    logic             accept, enter_resp, mem_we;
    logic             eff_we, eff_uns, eff_err;
    logic [1:0]       eff_size, off;
    logic [NBITS-1:0] eff_addr, eff_wdata;
    logic [AW-1:0]    idx;
    logic [NBITS-1:0] rword, rshift, load_data, wlane;
    logic [3:0]       be;

    assign accept     = bus.req_valid && (state_q == IDLE);
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // With LATENCY = 1 the accepting edge is also the commit edge, so the
    // access is decoded from the live request rather than the captured one.
    assign eff_we    = accept ? bus.req_we       : we_q;
    assign eff_uns   = accept ? bus.req_unsigned : uns_q;
    assign eff_size  = accept ? bus.req_size     : size_q;
    assign eff_addr  = accept ? bus.req_addr     : addr_q;
    assign eff_wdata = accept ? bus.req_wdata    : wdata_q;
    assign off       = eff_addr[1:0];
    assign idx       = eff_addr[AW+1:2];

    always_comb begin
        eff_err = 1'b0;
        case (eff_size)
            2'b01:   eff_err = eff_addr[0];
            2'b10:   eff_err = |eff_addr[1:0];
            2'b11:   eff_err = 1'b1;
            default: eff_err = 1'b0;
        endcase
        if (eff_addr[NBITS-1:2] >= (NBITS-2)'(DEPTH)) eff_err = 1'b1;
    end

    assign rword  = mem_q[idx];
    assign rshift = rword >> {off, 3'b000};

    always_comb begin
        load_data = '0;
        if (!eff_we && !eff_err) begin
            case (eff_size)
                2'b00:   load_data = eff_uns ? {24'd0, rshift[7:0]}
                                             : {{24{rshift[7]}}, rshift[7:0]};
                2'b01:   load_data = eff_uns ? {16'd0, rshift[15:0]}
                                             : {{16{rshift[15]}}, rshift[15:0]};
                default: load_data = rword;
            endcase
        end
    end

    always_comb begin
        be    = 4'b0000;
        wlane = eff_wdata;
        case (eff_size)
            2'b00: begin
                be    = 4'b0001 << off;
                wlane = {4{eff_wdata[7:0]}};
            end
            2'b01: begin
                be    = off[1] ? 4'b1100 : 4'b0011;
                wlane = {2{eff_wdata[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign mem_we = enter_resp && eff_we && !eff_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= load_data;
                err_q   <= eff_err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - 2'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.busy      = (state_q == WAIT) || (state_q == RESP);
        bus.rsp_valid = (state_q == RESP);
        bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        bus.rsp_err   = (state_q == RESP) && err_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded vector bench for dmem_responder (LATENCY 2 main instance,
// LATENCY 1 instance for throughput and same-edge load decode).
module tb_dmem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.NBITS(32)) bus0 ();
    dmem_responder_if #(.NBITS(32)) bus1 ();

    dmem_responder #(.NBITS(32), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    dmem_responder #(.NBITS(32), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    int   since    = 0;
    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Response monitor: pops the scoreboard and checks response timing.
    always @(negedge clk) begin
        since = since + 1;
        if (bus0.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", bus0.rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, bus0.rsp_err}, {31'd0, e.err});
                chk("rsp_latency", since, LAT);
                chk("busy_in_resp", {31'd0, bus0.busy}, 32'd1);
                chk("ready_in_resp", {31'd0, bus0.req_ready}, 32'd0);
            end
        end
        if (bus0.req_valid && bus0.req_ready) since = 0;
    end

    task automatic issue(input vec_t v);
        int n;
        exp_t e;
        @(posedge clk); #1;
        bus0.req_we       = v.we;
        bus0.req_addr     = v.addr;
        bus0.req_wdata    = v.wdata;
        bus0.req_size     = v.size;
        bus0.req_unsigned = v.uns;
        bus0.req_valid    = 1'b1;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb.push_back(e);
        n = 0;
        while (bus0.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int acc, rsp, last, n;
        logic prev;
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int acc, rsp, last;
        logic prev;
        vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, SZ_W, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  32'h0,        SZ_W, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h20,  32'h11223344, SZ_W, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'h21,  32'h00000080, SZ_B, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{1'b1, 32'h22,  32'h0000ABCD, SZ_H, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h20,  32'h0,        SZ_W, 1'b0, 32'hABCD8044, 1'b0};
        vecs[6]  = '{1'b0, 32'h21,  32'h0,        SZ_B, 1'b0, 32'hFFFFFF80, 1'b0};
        vecs[7]  = '{1'b0, 32'h21,  32'h0,        SZ_B, 1'b1, 32'h00000080, 1'b0};
        vecs[8]  = '{1'b0, 32'h22,  32'h0,        SZ_H, 1'b0, 32'hFFFFABCD, 1'b0};
        vecs[9]  = '{1'b0, 32'h22,  32'h0,        SZ_H, 1'b1, 32'h0000ABCD, 1'b0};
        vecs[10] = '{1'b0, 32'h23,  32'h0,        SZ_B, 1'b0, 32'hFFFFFFAB, 1'b0};
        vecs[11] = '{1'b0, 32'h22,  32'h0,        SZ_W, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{1'b1, 32'h13,  32'h0000FFFF, SZ_H, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, DEPTH*4, 32'h0,        SZ_W, 1'b0, 32'h0,        1'b1};
        vecs[14] = '{1'b1, 32'h10,  32'h12121212, SZ_X, 1'b0, 32'h0,        1'b1};
        vecs[15] = '{1'b0, 32'h10,  32'h0,        SZ_W, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[16] = '{1'b0, 32'h20,  32'h0,        SZ_W, 1'b0, 32'hABCD8044, 1'b0};
        vecs[17] = '{1'b1, (DEPTH-1)*4, 32'h12345678, SZ_W, 1'b0, 32'h0,    1'b0};
        vecs[18] = '{1'b0, (DEPTH-1)*4, 32'h0,    SZ_W, 1'b0, 32'h12345678, 1'b0};
        vecs[19] = '{1'b1, 32'h40,  32'h00000000, SZ_W, 1'b0, 32'h0,        1'b0};

        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_size = SZ_W; bus0.req_unsigned = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
        bus1.req_wdata = '0;   bus1.req_size = SZ_W; bus1.req_unsigned = 1'b0;

        #13;
        chk("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus0.busy}, 32'd0);
        chk("rst_rsp_rdata", bus0.rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, bus0.rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", {31'd0, bus0.req_ready}, 32'd1);

        for (int i = 0; i < 20; i++) issue(vecs[i]);

        // Continuous req_valid: one accept every LAT+1 cycles.
        @(posedge clk); #1;
        bus0.req_we = 1'b0; bus0.req_addr = 32'h10; bus0.req_size = SZ_W;
        bus0.req_unsigned = 1'b0; bus0.req_valid = 1'b1;
        acc = 0; rsp = 0; last = -1;
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            @(negedge clk);
            if (bus0.rsp_valid === 1'b1) rsp++;
            if (bus0.req_ready === 1'b1) begin
                e.rdata = 32'hDEADBEEF; e.err = 1'b0;
                sb.push_back(e);
                if (last >= 0) chk("accept_spacing", i - last, LAT + 1);
                last = i;
                acc++;
            end
        end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_accepts", acc, 4);
        chk("hold_rsp_pulses", rsp, 4);
        chk("hold_drained", sb.size(), 0);

        // Reset while the store sits in WAIT must drop it uncommitted.
        @(posedge clk); #1;
        bus0.req_we = 1'b1; bus0.req_addr = 32'h40; bus0.req_wdata = 32'h55;
        bus0.req_size = SZ_W; bus0.req_valid = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        chk("accepted_busy", {31'd0, bus0.busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus0.busy}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_ready", {31'd0, bus0.req_ready}, 32'd1);
        issue('{1'b0, 32'h40, 32'h0, SZ_W, 1'b0, 32'h0, 1'b0});

        // LATENCY = 1 instance: one accept every 2 cycles, response next cycle.
        @(posedge clk); #1;
        bus1.req_we = 1'b1; bus1.req_addr = 32'h8; bus1.req_wdata = 32'hCAFEF00D;
        bus1.req_size = SZ_W; bus1.req_unsigned = 1'b0; bus1.req_valid = 1'b1;
        acc = 0; rsp = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prev) chk("l1_rsp_after_accept", {31'd0, bus1.rsp_valid}, 32'd1);
            if (bus1.rsp_valid === 1'b1) rsp++;
            if (bus1.req_ready === 1'b1) acc++;
            prev = bus1.req_ready;
        end
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        chk("l1_accepts", acc, 5);
        chk("l1_rsp_pulses", rsp, 5);
        @(posedge clk); #1;
        bus1.req_we = 1'b0; bus1.req_addr = 32'h8; bus1.req_size = SZ_H;
        bus1.req_unsigned = 1'b0; bus1.req_valid = 1'b1;
        chk("l1_ready_idle", {31'd0, bus1.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus1.req_valid = 1'b0;
        chk("l1_load_valid", {31'd0, bus1.rsp_valid}, 32'd1);
        chk("l1_load_rdata", bus1.rsp_rdata, 32'hFFFFF00D);
        chk("l1_load_err", {31'd0, bus1.rsp_err}, 32'd0);
        @(posedge clk); #1;
        chk("l1_rdata_idle", bus1.rsp_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter NBITS, default 32, data/address width; only 32 is supported.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words stored.
REQ-003 Parameter LATENCY, default 2, legal 1..4; cycles from request acceptance to response.
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port req_valid, input, 1, datapath presents a load/store request.
REQ-007 Port req_ready, output, 1, responder can accept a request this cycle.
REQ-008 Port req_we, input, 1, 1 = store, 0 = load.
REQ-009 Port req_addr, input, NBITS, byte address.
REQ-010 Port req_wdata, input, NBITS, store data, right-aligned.
REQ-011 Port req_size, input, 2, 00 byte, 01 half, 10 word; 11 is illegal.
REQ-012 Port req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-013 Port rsp_valid, output, 1, one-cycle response/acknowledge pulse.
REQ-014 Port rsp_rdata, output, NBITS, extended load data; 0 for stores and errors.
REQ-015 Port rsp_err, output, 1, request was misaligned, illegal size, or out of range.
REQ-016 Port busy, output, 1, request outstanding; the control unit uses it as a stall source.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE.
- busy = 1 in WAIT and RESP.
REQ-018 On req_valid & req_ready, the block SHALL register we/addr/wdata/size/unsigned.
- Next state: RESP if LATENCY = 1, else WAIT.
- The latency counter loads with LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the next state is RESP.
- Net effect: rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 RESP SHALL last exactly one cycle with rsp_valid = 1, then return unconditionally to IDLE.
- Throughput is one request per LATENCY+1 cycles; requests in RESP are not accepted.
REQ-021 Error detection (rsp_err = 1) SHALL flag:
- half access with addr[0] = 1;
- word access with addr[1:0] != 0;
- size = 11;
- addr[NBITS-1:2] >= DEPTH.
REQ-022 An erroneous request SHALL NOT modify memory and SHALL return rsp_rdata = 0.
REQ-023 Stores SHALL commit on the edge entering RESP, writing only the addressed lanes:
- byte: lane addr[1:0] ← wdata[7:0];
- half: lanes addr[1]*2..+1 ← wdata[15:0];
- word: all four lanes.
REQ-024 Loads SHALL sample memory on the edge entering RESP.
- Extract the addressed byte/half/word and extend per req_unsigned.
- rsp_rdata is valid only while rsp_valid = 1 and is 0 otherwise.
REQ-025 Memory is little-endian; lane 0 = bits 7:0.
REQ-026 A load following a store to the same address SHALL return the stored data (no stale read).
REQ-027 Inputs other than req_valid are don't-care when req_valid = 0 or req_ready = 0.

Reset
REQ-028 rst low SHALL immediately force:
- state IDLE, counter 0;
- rsp_valid, rsp_err, busy 0; rsp_rdata 0; req_ready 1 after release.
REQ-029 Reset asserted in WAIT SHALL drop the pending request; an uncommitted store SHALL NOT write.
REQ-030 Memory contents SHALL NOT be reset and are undefined until written.

Verification (LATENCY = 2 unless stated)
REQ-031 Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10.
- Each rsp_valid fires 2 cycles after acceptance; the load returns 0xDEADBEEF with rsp_err = 0.
REQ-032 Byte/half lanes: SW 0x11223344 @0x20, SB 0x80 @0x21, SH 0xABCD @0x22.
- LW @0x20 → 0xABCD8044; LB @0x21 → 0xFFFFFF80; LBU @0x21 → 0x00000080; LH @0x22 → 0xFFFFABCD.
REQ-033 Errors each return rsp_err = 1, rsp_rdata = 0, with memory unchanged (confirmed by readback):
- LW @0x22; SH @0x13; LW @DEPTH*4.
REQ-034 Handshake: hold req_valid high continuously.
- req_ready = 0 during WAIT/RESP; exactly one accept per 3 cycles; one rsp_valid pulse per accept.
- LATENCY = 1 gives one accept per 2 cycles.
REQ-035 Reset mid-operation: SW 0x55 @0x40 over 0x0, assert rst one cycle after acceptance.
- No rsp_valid; busy = 0; LW @0x40 after release → 0x00000000.
